// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and the surrounding system.
// The sequencer owns the master side; whatever wires it up (PLL, status logic, bench) uses the slave side.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       soft_reset_req;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       video_reset_n;
    logic [2:0] seq_state;
    logic [3:0] retry_count;
    logic       lock_lost;
    logic       pll_fail;

    modport master (
        input  pll_locked,
        input  soft_reset_req,
        output pll_rst,
        output sys_reset_n,
        output video_reset_n,
        output seq_state,
        output retry_count,
        output lock_lost,
        output pll_fail
    );

    modport slave (
        output pll_locked,
        output soft_reset_req,
        input  pll_rst,
        input  sys_reset_n,
        input  video_reset_n,
        input  seq_state,
        input  retry_count,
        input  lock_lost,
        input  pll_fail
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer running on the free-running reference clock: drives the PLL reset,
// qualifies lock, then releases the system reset before the video reset and reruns on lock loss.
module pll_reset_sequencer #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 1048576,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RELEASE_GAP_CYCLES  = 8,
    parameter int MAX_RETRIES         = 7
) (
    input  logic                         clk_74a,
    input  logic                         reset_n,
    pll_reset_sequencer_if.master        seq_if
);

    localparam int MAX_AB  = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CD  = (LOCK_STABLE_CYCLES > RELEASE_GAP_CYCLES) ? LOCK_STABLE_CYCLES : RELEASE_GAP_CYCLES;
    localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_CNT) + 1;

    // Terminal values: each timed state lasts exactly its parameter in cycles.
    localparam logic [CW-1:0] C_HOLD_LAST    = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] C_TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] C_STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] C_GAP_LAST     = CW'(RELEASE_GAP_CYCLES - 1);
    localparam logic [3:0]    C_MAX_RETRIES  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    logic          r_lock_meta;
    logic          r_lock_s;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_retry;
    logic          r_lock_lost;
    logic          r_pll_fail;
    logic          r_pll_rst;
    logic          r_sys_rst_n;
    logic          r_video_rst_n;

    state_t        w_state_next;
    logic [3:0]    w_retry_next;
    logic [3:0]    w_retry_inc;
    logic          w_lock_lost_next;
    logic          w_pll_fail_next;
    logic          w_restart;
    logic          w_cnt_run;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= seq_if.pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    assign w_retry_inc = r_retry + 4'd1;

    always_comb begin
        w_state_next     = r_state;
        w_retry_next     = r_retry;
        w_lock_lost_next = r_lock_lost;
        w_pll_fail_next  = r_pll_fail;
        if (seq_if.soft_reset_req) begin
            w_state_next     = ST_RESET_PLL;
            w_retry_next     = 4'd0;
            w_lock_lost_next = 1'b0;
            w_pll_fail_next  = 1'b0;
        end else begin
            case (r_state)
                ST_RESET_PLL: begin
                    if (r_cnt == C_HOLD_LAST)
                        w_state_next = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    // Lock is tested first so it wins over a coincident timeout.
                    if (r_lock_s) begin
                        w_state_next = ST_STABILIZE;
                    end else if (r_cnt == C_TIMEOUT_LAST) begin
                        w_retry_next = w_retry_inc;
                        if (w_retry_inc == C_MAX_RETRIES) begin
                            w_state_next    = ST_FAIL;
                            w_pll_fail_next = 1'b1;
                        end else begin
                            w_state_next = ST_RESET_PLL;
                        end
                    end
                end
                ST_STABILIZE: begin
                    if (!r_lock_s)
                        w_state_next = ST_WAIT_LOCK;
                    else if (r_cnt == C_STABLE_LAST)
                        w_state_next = ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!r_lock_s) begin
                        w_state_next     = ST_RESET_PLL;
                        w_lock_lost_next = 1'b1;
                    end else if (r_cnt == C_GAP_LAST) begin
                        w_state_next = ST_RUN;
                        w_retry_next = 4'd0;
                    end
                end
                ST_RUN: begin
                    if (!r_lock_s) begin
                        w_state_next     = ST_RESET_PLL;
                        w_lock_lost_next = 1'b1;
                    end
                end
                ST_FAIL: begin
                    w_state_next = ST_FAIL;
                end
                default: begin
                    w_state_next = ST_RESET_PLL;
                end
            endcase
        end
    end

    // A soft reset re-enters RESET_PLL even from RESET_PLL, so it restarts the hold count too.
    assign w_restart = seq_if.soft_reset_req || (w_state_next != r_state);
    assign w_cnt_run = (r_state != ST_RUN) && (r_state != ST_FAIL);

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_RESET_PLL;
            r_cnt         <= '0;
            r_retry       <= 4'd0;
            r_lock_lost   <= 1'b0;
            r_pll_fail    <= 1'b0;
            r_pll_rst     <= 1'b1;
            r_sys_rst_n   <= 1'b0;
            r_video_rst_n <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_retry     <= w_retry_next;
            r_lock_lost <= w_lock_lost_next;
            r_pll_fail  <= w_pll_fail_next;
            if (w_restart)
                r_cnt <= '0;
            else if (w_cnt_run)
                r_cnt <= r_cnt + 1'b1;
            // Reset outputs are flops decoded from the next state so they never glitch.
            r_pll_rst     <= (w_state_next == ST_RESET_PLL);
            r_sys_rst_n   <= (w_state_next == ST_RELEASE) || (w_state_next == ST_RUN);
            r_video_rst_n <= (w_state_next == ST_RUN);
        end
    end

    assign seq_if.pll_rst       = r_pll_rst;
    assign seq_if.sys_reset_n   = r_sys_rst_n;
    assign seq_if.video_reset_n = r_video_rst_n;
    assign seq_if.seq_state     = r_state;
    assign seq_if.retry_count   = r_retry;
    assign seq_if.lock_lost     = r_lock_lost;
    assign seq_if.pll_fail      = r_pll_fail;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: the stimulus queues expected state transitions,
// the monitor checks each transition's outputs and the dwell time of the state being left.
module tb_pll_reset_sequencer;

    localparam int S_RST  = 0;
    localparam int S_WAIT = 1;
    localparam int S_STAB = 2;
    localparam int S_REL  = 3;
    localparam int S_RUN  = 4;
    localparam int S_FAIL = 5;

    typedef struct {
        int   st;
        int   dwell;
        logic pll_rst;
        logic sys_n;
        logic vid_n;
        int   retry;
        logic ll;
        logic pf;
    } exp_t;

    logic clk_74a = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    pll_reset_sequencer_if sig();

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES(32),
        .LOCK_STABLE_CYCLES (8),
        .RELEASE_GAP_CYCLES (3),
        .MAX_RETRIES        (2)
    ) dut (
        .clk_74a(clk_74a),
        .reset_n(reset_n),
        .seq_if (sig)
    );

    always #5 clk_74a = ~clk_74a;

    task automatic expect_tr(input int st, input int dwell, input logic r, input logic s,
                             input logic v, input int retry, input logic ll, input logic pf);
        exp_t e;
        e.st = st; e.dwell = dwell; e.pll_rst = r; e.sys_n = s; e.vid_n = v;
        e.retry = retry; e.ll = ll; e.pf = pf;
        exp_q.push_back(e);
    endtask

    task automatic wait_state(input int st, input int budget);
        int n;
        n = 0;
        @(negedge clk_74a);
        while (int'(sig.seq_state) != st && n < budget) begin
            @(negedge clk_74a);
            n++;
        end
        if (int'(sig.seq_state) != st) begin
            $display("FAIL wait_state: state=%0d after %0d cycles, required %0d", sig.seq_state, n, st);
            miscompares++;
        end
    endtask

    // Locks the PLL 10 cycles after pll_rst falls (i.e. after WAIT_LOCK entry).
    task automatic lock_after_10();
        wait_state(S_WAIT, 200);
        repeat (10) @(negedge clk_74a);
        sig.pll_locked = 1'b1;
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin : monitor
        int   prev_state;
        int   dwell;
        int   ntr;
        exp_t e;
        prev_state = 7;
        dwell = 0;
        ntr = 0;
        forever begin
            @(posedge clk_74a);
            #1;
            if (sig.video_reset_n && !sig.sys_reset_n) begin
                $display("FAIL invariant_vid_sys: video_reset_n=1 while sys_reset_n=0 at %0t", $time);
                miscompares++;
            end
            if (sig.pll_rst && (sig.sys_reset_n || sig.video_reset_n)) begin
                $display("FAIL invariant_pllrst: reset released while pll_rst=1 at %0t", $time);
                miscompares++;
            end
            if (int'(sig.seq_state) != prev_state) begin
                ntr++;
                vectors++;
                if (exp_q.size() == 0) begin
                    $display("FAIL trans%0d: unexpected transition to state %0d at %0t", ntr, sig.seq_state, $time);
                    miscompares++;
                end else begin
                    e = exp_q.pop_front();
                    if (int'(sig.seq_state) != e.st || sig.pll_rst !== e.pll_rst ||
                        sig.sys_reset_n !== e.sys_n || sig.video_reset_n !== e.vid_n ||
                        int'(sig.retry_count) != e.retry || sig.lock_lost !== e.ll ||
                        sig.pll_fail !== e.pf || (e.dwell >= 0 && dwell != e.dwell)) begin
                        $display("FAIL trans%0d: got st=%0d rst=%b sys=%b vid=%b retry=%0d ll=%b pf=%b prev_dwell=%0d; required st=%0d rst=%b sys=%b vid=%b retry=%0d ll=%b pf=%b prev_dwell=%0d",
                                 ntr, sig.seq_state, sig.pll_rst, sig.sys_reset_n, sig.video_reset_n,
                                 sig.retry_count, sig.lock_lost, sig.pll_fail, dwell,
                                 e.st, e.pll_rst, e.sys_n, e.vid_n, e.retry, e.ll, e.pf, e.dwell);
                        miscompares++;
                    end else begin
                        $display("trans%0d ok: state %0d (previous state held %0d cycles)", ntr, sig.seq_state, dwell);
                    end
                end
                dwell = 1;
            end else begin
                dwell++;
            end
            if (!reset_n) dwell = 0;
            prev_state = int'(sig.seq_state);
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        sig.pll_locked     = 1'b0;
        sig.soft_reset_req = 1'b0;
        reset_n            = 1'b0;

        // A: reset values, then lock 10 cycles after pll_rst falls -> full release.
        expect_tr(S_RST,  -1, 1, 0, 0, 0, 0, 0);
        expect_tr(S_WAIT, -1, 0, 0, 0, 0, 0, 0);
        expect_tr(S_STAB, 13, 0, 0, 0, 0, 0, 0);
        expect_tr(S_REL,   8, 0, 1, 0, 0, 0, 0);
        expect_tr(S_RUN,   3, 0, 1, 1, 0, 0, 0);
        repeat (3) @(negedge clk_74a);
        reset_n = 1'b1;
        lock_after_10();
        wait_state(S_RUN, 200);

        // B: lock lost in RUN -> 2 sync + 1 cycle later back to RESET_PLL; relock keeps lock_lost.
        expect_tr(S_RST,   3, 1, 0, 0, 0, 1, 0);
        expect_tr(S_WAIT,  4, 0, 0, 0, 0, 1, 0);
        expect_tr(S_STAB, 13, 0, 0, 0, 0, 1, 0);
        expect_tr(S_REL,   8, 0, 1, 0, 0, 1, 0);
        expect_tr(S_RUN,   3, 0, 1, 1, 0, 1, 0);
        sig.pll_locked = 1'b0;
        lock_after_10();
        wait_state(S_RUN, 200);

        // C: soft reset coincides with the synced lock drop -> flags cleared; no lock -> FAIL.
        expect_tr(S_RST,   3, 1, 0, 0, 0, 0, 0);
        expect_tr(S_WAIT,  4, 0, 0, 0, 0, 0, 0);
        expect_tr(S_RST,  32, 1, 0, 0, 1, 0, 0);
        expect_tr(S_WAIT,  4, 0, 0, 0, 1, 0, 0);
        expect_tr(S_FAIL, 32, 0, 0, 0, 2, 0, 1);
        sig.pll_locked = 1'b0;
        repeat (2) @(negedge clk_74a);
        sig.soft_reset_req = 1'b1;
        @(negedge clk_74a);
        sig.soft_reset_req = 1'b0;
        wait_state(S_FAIL, 200);

        // D: soft reset out of FAIL; one-cycle lock glitch in STABILIZE; async reset in RELEASE.
        expect_tr(S_RST,   6, 1, 0, 0, 0, 0, 0);
        expect_tr(S_WAIT,  4, 0, 0, 0, 0, 0, 0);
        expect_tr(S_STAB, 13, 0, 0, 0, 0, 0, 0);
        expect_tr(S_WAIT,  8, 0, 0, 0, 0, 0, 0);
        expect_tr(S_STAB,  1, 0, 0, 0, 0, 0, 0);
        expect_tr(S_REL,   8, 0, 1, 0, 0, 0, 0);
        expect_tr(S_RST,   1, 1, 0, 0, 0, 0, 0);
        expect_tr(S_WAIT, -1, 0, 0, 0, 0, 0, 0);
        expect_tr(S_STAB, 13, 0, 0, 0, 0, 0, 0);
        expect_tr(S_REL,   8, 0, 1, 0, 0, 0, 0);
        expect_tr(S_RUN,   3, 0, 1, 1, 0, 0, 0);
        repeat (5) @(negedge clk_74a);
        sig.soft_reset_req = 1'b1;
        @(negedge clk_74a);
        sig.soft_reset_req = 1'b0;
        lock_after_10();
        wait_state(S_STAB, 200);
        repeat (5) @(negedge clk_74a);
        sig.pll_locked = 1'b0;
        @(negedge clk_74a);
        sig.pll_locked = 1'b1;
        wait_state(S_REL, 200);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (sig.sys_reset_n !== 1'b0 || sig.video_reset_n !== 1'b0 || sig.pll_rst !== 1'b1) begin
            $display("FAIL async_reset: sys=%b vid=%b pll_rst=%b, required sys=0 vid=0 pll_rst=1",
                     sig.sys_reset_n, sig.video_reset_n, sig.pll_rst);
            miscompares++;
        end else begin
            $display("async_reset ok: resets asserted immediately");
        end
        sig.pll_locked = 1'b0;
        repeat (3) @(negedge clk_74a);
        reset_n = 1'b1;
        lock_after_10();
        wait_state(S_RUN, 200);
        repeat (5) @(negedge clk_74a);

        vectors++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expected transitions never seen, required 0", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
